// File: rtl/bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// bcd_serial_adder
//
// Multi-digit packed-BCD adder that works one decimal digit per clock, least
// significant digit first. A start/busy/done handshake fronts the block. The
// registered result is loaded when the last digit has been processed, so
// sum/cout/err are valid in the same cycle that done is high.
//
// Optional feature (compile-time macro BCD_SUBTRACT_EN):
//   Adds input port 'sub'. When sub=1 each B digit is replaced by its nine's
//   complement before the add. With c=1 this gives a - b mod 10^DIGITS, and
//   cout=1 means no borrow. Without the macro the block only adds.
//
// Parameters:
//   DIGITS  number of BCD digits per operand (1..16)
//   CNT_W   width of the digit index counter, 2**CNT_W >= DIGITS
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   start  operation request, sampled only when not busy
//   a, b   packed BCD operands, digit 0 in bits [3:0]
//   c      decimal carry-in to digit 0
//   sub    (BCD_SUBTRACT_EN only) subtract b instead of adding it
//   busy   high while digits are being processed
//   done   one-cycle pulse when sum/cout/err become valid
//   sum    packed BCD result, registered
//   cout   decimal carry out of the most significant digit
//   err    set if any operand digit of the finished operation was above 9
// ---------------------------------------------------------------------------
module bcd_serial_adder #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  c,
`ifdef BCD_SUBTRACT_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

  logic [1:0]          state;
  logic [4*DIGITS-1:0] a_reg;
  logic [4*DIGITS-1:0] b_reg;
  logic                carry;
  logic [CNT_W-1:0]    idx;
  logic [4*DIGITS-1:0] work_sum;
  logic                work_err;
`ifdef BCD_SUBTRACT_EN
  logic                sub_reg;
`endif

  logic [3:0]          a_d;
  logic [3:0]          b_raw;
  logic [3:0]          b_d;
  logic [4:0]          t;
  logic [3:0]          digit;
  logic                carry_next;
  logic                err_next;
  logic [4*DIGITS-1:0] sum_next;

  // One digit of decimal addition on the digit selected by idx. Invalid
  // digits still go through the same correction so nothing turns into X;
  // they only raise the working error flag. The working sum with the new
  // digit merged in is formed here so the final digit can be loaded straight
  // into the output register on the last RUN cycle.
  always_comb begin
    a_d   = a_reg[4*idx +: 4];
    b_raw = b_reg[4*idx +: 4];
`ifdef BCD_SUBTRACT_EN
    b_d   = sub_reg ? (4'd9 - b_raw) : b_raw;
`else
    b_d   = b_raw;
`endif
    t = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, carry};
    if (t > 5'd9) begin
      digit      = 4'(t + 5'd6);
      carry_next = 1'b1;
    end else begin
      digit      = t[3:0];
      carry_next = 1'b0;
    end
    err_next = work_err | (a_d > 4'd9) | (b_raw > 4'd9);
    sum_next = work_sum;
    sum_next[4*idx +: 4] = digit;
  end

  // Sequencer. A new request is taken both from IDLE and from the DONE
  // cycle so operations can run back to back; requests during RUN are
  // dropped. Reset clears everything, aborting any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      work_sum <= '0;
      work_err <= 1'b0;
`ifdef BCD_SUBTRACT_EN
      sub_reg  <= 1'b0;
`endif
      sum      <= '0;
      cout     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= b;
            carry    <= c;
            idx      <= '0;
            work_sum <= '0;
            work_err <= 1'b0;
`ifdef BCD_SUBTRACT_EN
            sub_reg  <= sub;
`endif
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          work_sum <= sum_next;
          work_err <= err_next;
          carry    <= carry_next;
          idx      <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            sum   <= sum_next;
            cout  <= carry_next;
            err   <= err_next;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_adder
//
// Self-checking bench for bcd_serial_adder. Two instances share clock and
// reset: a 4-digit adder for the multi-digit scenarios and a 1-digit adder
// for the exhaustive single-digit sweep. Expected results are pushed onto a
// per-instance queue whenever a request is driven and popped by a monitor
// whenever that instance pulses done. Define BCD_SUBTRACT_EN for both the
// bench and the design to include the subtract scenario.
// ---------------------------------------------------------------------------
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4;
  logic [15:0] a4, b4;
  logic        c4, sub4;
  logic        busy4, done4, cout4, err4;
  logic [15:0] sum4;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        c1, sub1;
  logic        busy1, done1, cout1, err1;
  logic [3:0]  sum1;

  int compare_count = 0;
  int fail_count    = 0;

  logic [17:0] q4[$];
  logic [5:0]  q1[$];

  int lat, busy_cnt;

  bcd_serial_adder #(.DIGITS(4), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .c     (c4),
`ifdef BCD_SUBTRACT_EN
    .sub   (sub4),
`endif
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4),
    .err   (err4)
  );

  bcd_serial_adder #(.DIGITS(1), .CNT_W(4)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .c     (c1),
`ifdef BCD_SUBTRACT_EN
    .sub   (sub1),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .err   (err1)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference model returning {err, cout, sum}. Valid operands are modelled
  // as plain decimal arithmetic; operands with a bad digit fall back to the
  // digit-by-digit correction so the flagged result is still predictable.
  function automatic logic [17:0] model4(input logic [15:0] a, input logic [15:0] b,
                                         input logic c, input logic s);
    logic        bad = 1'b0;
    logic [15:0] r = '0;
    logic        cy;
    int          ai, bi, tot, t;
    logic [3:0]  bd;
    for (int i = 0; i < 4; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    if (!bad) begin
      ai = bcd2int(a);
      bi = bcd2int(b);
      if (s) bi = 9999 - bi;
      tot = ai + bi + int'(c);
      return {1'b0, (tot >= 10000), int2bcd(tot % 10000)};
    end
    cy = c;
    for (int i = 0; i < 4; i++) begin
      bd = s ? 4'(4'd9 - b[4*i +: 4]) : b[4*i +: 4];
      t  = int'(a[4*i +: 4]) + int'(bd) + int'(cy);
      if (t > 9) begin
        r[4*i +: 4] = 4'((t + 6) % 16);
        cy = 1'b1;
      end else begin
        r[4*i +: 4] = 4'(t);
        cy = 1'b0;
      end
    end
    return {1'b1, cy, r};
  endfunction

  // Drive one request to the 4-digit adder from a falling edge and record
  // its expected result; start is held across exactly one rising edge.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                               input logic tc, input logic ts);
    a4 = ta; b4 = tb; c4 = tc; sub4 = ts; start4 = 1'b1;
    q4.push_back(model4(ta, tb, tc, ts));
    @(negedge clk);
    start4 = 1'b0;
  endtask

  // Same for the 1-digit adder, modelled directly as decimal a + b + c
  task automatic applyStimulus1(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    int t;
    a1 = ta; b1 = tb; c1 = tc; start1 = 1'b1;
    t = int'(ta) + int'(tb) + int'(tc);
    q1.push_back({1'b0, (t >= 10), 4'(t % 10)});
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // Wait for done on the 4-digit adder. lat counts rising edges from the
  // start edge to the edge that samples done high; busy_c counts the falling
  // edges on which busy was seen in between.
  task automatic waitDone4(output int lt, output int busy_c);
    bit ok = 1'b0;
    lt = 0;
    busy_c = 0;
    for (int i = 0; i < 40; i++) begin
      if (done4) begin
        lt = i + 1;
        ok = 1'b1;
        break;
      end
      if (busy4) busy_c++;
      @(negedge clk);
    end
    if (!ok) checkOutput("done4_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDone1();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("done1_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitors: every done pulse must match the oldest request
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst && done4) begin
      if (q4.size() == 0) checkOutput("sb4_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        checkOutput("sb4_sum",  32'(sum4), 32'(e[15:0]));
        checkOutput("sb4_cout", 32'(cout4), 32'(e[16]));
        checkOutput("sb4_err",  32'(err4), 32'(e[17]));
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] e;
    if (!rst && done1) begin
      if (q1.size() == 0) checkOutput("sb1_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        checkOutput("sb1_sum",  32'(sum1), 32'(e[3:0]));
        checkOutput("sb1_cout", 32'(cout1), 32'(e[4]));
        checkOutput("sb1_err",  32'(err1), 32'(e[5]));
      end
    end
  end

  // Hard stop in case a wait escapes its bound
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0; sub4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; sub1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_sum",  32'(sum4), 32'd0);
    checkOutput("reset_cout", 32'(cout4), 32'd0);
    checkOutput("reset_err",  32'(err4), 32'd0);
    checkOutput("reset_busy", 32'(busy4), 32'd0);
    checkOutput("reset_done", 32'(done4), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single-digit exhaustive sweep");
    for (int ia = 0; ia < 10; ia++)
      for (int ib = 0; ib < 10; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          applyStimulus1(4'(ia), 4'(ib), 1'(ic));
          waitDone1();
        end
    // Invalid digit A + 0: corrected as 10 -> digit 0, carry 1, flagged
    a1 = 4'hA; b1 = 4'h0; c1 = 1'b0; start1 = 1'b1;
    q1.push_back({1'b1, 1'b1, 4'h0});
    @(negedge clk);
    start1 = 1'b0;
    waitDone1();
    checkOutput("d1_invalid_err", 32'(err1), 32'd1);

    $display("[TB] latency and simple carry");
    applyStimulus(16'h0000, 16'h0009, 1'b1, 1'b0);
    waitDone4(lat, busy_cnt);
    checkOutput("t1_latency", 32'(lat), 32'd5);
    checkOutput("t1_busy_cycles", 32'(busy_cnt), 32'd4);
    checkOutput("t1_sum", 32'(sum4), 32'h0010);
    checkOutput("t1_cout", 32'(cout4), 32'd0);

    $display("[TB] full ripple and back-to-back request");
    applyStimulus(16'h9999, 16'h0001, 1'b0, 1'b0);
    waitDone4(lat, busy_cnt);
    checkOutput("t2a_sum", 32'(sum4), 32'h0000);
    checkOutput("t2a_cout", 32'(cout4), 32'd1);
    applyStimulus(16'h4567, 16'h5432, 1'b1, 1'b0);
    checkOutput("t2b_b2b_busy", 32'(busy4), 32'd1);
    waitDone4(lat, busy_cnt);
    checkOutput("t2b_latency", 32'(lat), 32'd5);
    checkOutput("t2b_cout", 32'(cout4), 32'd1);

    $display("[TB] invalid digit and sticky error");
    applyStimulus(16'h12F4, 16'h0001, 1'b0, 1'b0);
    waitDone4(lat, busy_cnt);
    checkOutput("t5_err_set", 32'(err4), 32'd1);
    applyStimulus(16'h0011, 16'h0022, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t5_err_hold", 32'(err4), 32'd1);
      checkOutput("t5_sum_hold", 32'(sum4), 32'h1355);
      @(negedge clk);
    end
    waitDone4(lat, busy_cnt);
    checkOutput("t5_err_clear", 32'(err4), 32'd0);

    $display("[TB] start while busy is ignored");
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    a4 = 16'h9999; b4 = 16'h9999; c4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    waitDone4(lat, busy_cnt);
    checkOutput("t4_orig_sum", 32'(sum4), 32'h2345);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("t4_no_extra_done", 32'(done4), 32'd0);
    end

    $display("[TB] reset mid-operation");
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    q4.delete();
    #1;
    checkOutput("rst_sum",  32'(sum4), 32'd0);
    checkOutput("rst_cout", 32'(cout4), 32'd0);
    checkOutput("rst_err",  32'(err4), 32'd0);
    checkOutput("rst_busy", 32'(busy4), 32'd0);
    checkOutput("rst_done", 32'(done4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("rst_no_done", 32'(done4), 32'd0);
    end
    applyStimulus(16'h0250, 16'h0750, 1'b0, 1'b0);
    waitDone4(lat, busy_cnt);
    checkOutput("rst_recover_sum", 32'(sum4), 32'h1000);

`ifdef BCD_SUBTRACT_EN
    $display("[TB] nine's complement subtract");
    applyStimulus(16'h0500, 16'h0123, 1'b1, 1'b1);
    waitDone4(lat, busy_cnt);
    checkOutput("t6a_sum", 32'(sum4), 32'h0377);
    checkOutput("t6a_cout", 32'(cout4), 32'd1);
    applyStimulus(16'h0100, 16'h0200, 1'b1, 1'b1);
    waitDone4(lat, busy_cnt);
    checkOutput("t6b_sum", 32'(sum4), 32'h9900);
    checkOutput("t6b_cout", 32'(cout4), 32'd0);
`endif

    repeat (2) @(negedge clk);
    checkOutput("sb4_drained", 32'(q4.size()), 32'd0);
    checkOutput("sb1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Parametrised multi-digit BCD adder. Generalises the existing 4-bit single-digit BCD add (a, b, carry-in, tens/units digit out) to DIGITS packed BCD digits, processed digit-serially, one digit per clock, LSD first. A start/busy/done handshake fronts the block. The result is a registered packed-BCD sum, a decimal carry-out and a sticky invalid-digit flag. It sits between operand registers and the display/result path.

Parameters:
DIGITS, 4, number of BCD digits per operand (1..16).
CNT_W, 4, width of the digit index counter; must satisfy 2**CNT_W >= DIGITS.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when not busy.
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
b  input  4*DIGITS  operand B, packed BCD.
c  input  1  decimal carry-in to digit 0.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when sum/cout/err become valid.
sum  output  4*DIGITS  packed BCD result, registered.
cout  output  1  decimal carry out of the most significant digit.
err  output  1  set if any operand digit was greater than 9.

Behaviour:
- Reset (async, rst=1): state IDLE. busy=0, done=0, sum=0, cout=0, err=0. Internal operand, carry and index registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch a, b and c into internal registers, clear the working sum and err, set idx=0, go to RUN. busy=1 from the next cycle.
- RUN, each cycle, on digit idx:
  - t = a_d + b_d + carry, computed 5 bits wide.
  - If t > 9: digit = (t + 6) mod 16 and carry = 1. Otherwise digit = t and carry = 0.
  - If a_d > 9 or b_d > 9, the working err is set. The digit is still computed with the same formula, so no X propagates.
  - The digit is written into the working sum at position idx, and idx increments.
  - After digit DIGITS-1, go to DONE.
- DONE, lasting one cycle:
  - done=1 and busy=0.
  - sum, cout and err outputs are loaded from the working registers.
  - Next state is IDLE, or RUN if start=1 in this cycle; back-to-back operations are legal.
- Outputs sum, cout and err change only in the DONE cycle and hold until the next DONE or reset.
- Latency: with start sampled at edge k, busy is high on edges k+1..k+DIGITS and done is high at edge k+DIGITS+1.
- start while busy: ignored. It is not queued and the operands are not relatched.
- Operand inputs may change freely after the start edge.
- Reset mid-operation: aborts immediately. No done pulse; all outputs return to reset values.
- DIGITS=1 is equivalent to the existing single-digit adder, with sum[3:0] as units and cout as tens.

Optional Feature:
Macro BCD_SUBTRACT_EN.
- Defined: adds input port sub (1 bit), latched with the operands at start. With sub=1, each B digit is replaced by its nine's complement (9 - b_d) before addition. The result is a + (10^DIGITS - 1 - b) + c. With c=1 this is a - b mod 10^DIGITS, and cout=1 means no borrow (a >= b). For an invalid b digit (>9), err is set and the complement is computed 4-bit modulo.
- Undefined: no sub port; addition only; logic identical to sub=0.

Test Plan:
1. DIGITS=4, a=16'h0000, b=16'h0009, c=1, start pulse -> done exactly 5 cycles after the start edge; sum=16'h0010, cout=0, err=0; busy high for 4 cycles.
2. DIGITS=4, a=16'h9999, b=16'h0001, c=0 -> sum=16'h0000, cout=1. Then a=16'h4567, b=16'h5432, c=1 issued in the DONE cycle -> accepted back-to-back; sum=16'h0000, cout=1.
3. DIGITS=1, exhaustive a,b in 0..9, c in {0,1} -> {cout, sum} equals decimal a+b+c for all 200 cases, err=0. Also a=4'hA -> err=1.
4. DIGITS=4: start, then start re-pulsed at cycle 2 with different operands -> ignored, original result returned. Then rst asserted at cycle 3 of a new operation -> all outputs 0 asynchronously, no done pulse.
5. DIGITS=4, a=16'h12F4 -> err=1 on done; err stays 1 until the next operation with valid digits completes.
6. BCD_SUBTRACT_EN, DIGITS=4, sub=1, c=1: a=16'h0500, b=16'h0123 -> sum=16'h0377, cout=1. Then a=16'h0100, b=16'h0200 -> sum=16'h9900, cout=0.
